wshb_arbiter: RTL and testbench

- Two-master, one-slave Wishbone classic arbiter that shares the SDRAM controller port between the display reader (master 0, VGA frame fetch) and a frame writer (master 1, e.g. pattern/image generator).
- Sits between both masters and the SDRAM Wishbone slave, in the Wishbone clock domain.
- Round-robin grant with a per-grant ack quota, so a master that holds cyc permanently (the display reader does) cannot starve the other.

---
 rtl/wshb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_wshb_arbiter.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wshb_arbiter.sv
// wshb_arbiter: two-master, one-slave Wishbone classic arbiter in front of the
// SDRAM controller. Master 0 is the display reader, master 1 the frame writer.
// Round-robin grant with a per-grant ack quota (MAX_BURST), so a master that
// holds cyc permanently cannot starve the other one.
//
// Ports:
//   clk, rst_n              Wishbone clock, asynchronous active-low reset
//   m0_* / m1_*             master-side cyc/stb/we/adr/dat_ms/sel in, ack out
//   dat_sm                  slave read data broadcast to both masters
//   s_*                     slave-side cyc/stb/we/adr/dat_ms/sel out, ack/dat_sm in
//   gnt                     one-hot registered grant (bit i = master i owns slave)
//   stat_ack0/1, stat_wait1 optional statistics, present only when the
//                           WSHB_ARB_STATS_EN macro is defined
module wshb_arbiter #(
    parameter int unsigned ADR_W     = 32,
    parameter int unsigned DAT_W     = 32,
    parameter int unsigned MAX_BURST = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 m0_cyc,
    input  logic                 m0_stb,
    input  logic                 m0_we,
    input  logic [ADR_W-1:0]     m0_adr,
    input  logic [DAT_W-1:0]     m0_dat_ms,
    input  logic [DAT_W/8-1:0]   m0_sel,
    output logic                 m0_ack,
    input  logic                 m1_cyc,
    input  logic                 m1_stb,
    input  logic                 m1_we,
    input  logic [ADR_W-1:0]     m1_adr,
    input  logic [DAT_W-1:0]     m1_dat_ms,
    input  logic [DAT_W/8-1:0]   m1_sel,
    output logic                 m1_ack,
    output logic [DAT_W-1:0]     dat_sm,
    output logic                 s_cyc,
    output logic                 s_stb,
    output logic                 s_we,
    output logic [ADR_W-1:0]     s_adr,
    output logic [DAT_W-1:0]     s_dat_ms,
    output logic [DAT_W/8-1:0]   s_sel,
    input  logic                 s_ack,
    input  logic [DAT_W-1:0]     s_dat_sm,
    output logic [1:0]           gnt
`ifdef WSHB_ARB_STATS_EN
    ,
    output logic [31:0]          stat_ack0,
    output logic [31:0]          stat_ack1,
    output logic [31:0]          stat_wait1
`endif
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] QUOTA_LAST = CNT_W'(MAX_BURST - 1);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;   // last-served master

    // State register, burst counter and last-served pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: grant changes only on a completed transfer or a cyc drop.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (m0_cyc && m1_cyc) begin
                    state_d = last_q ? GNT0 : GNT1;
                end else if (m0_cyc) begin
                    state_d = GNT0;
                end else if (m1_cyc) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc) begin
                    state_d = m1_cyc ? GNT1 : IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end else if (s_ack) begin
                    if (cnt_q == QUOTA_LAST && m1_cyc) begin
                        state_d = GNT1;
                        cnt_d   = '0;
                        last_d  = 1'b0;
                    end else if (cnt_q != QUOTA_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GNT1: begin
                if (!m1_cyc) begin
                    state_d = m0_cyc ? GNT0 : IDLE;
                    cnt_d   = '0;
                    last_d  = 1'b1;
                end else if (s_ack) begin
                    if (cnt_q == QUOTA_LAST && m0_cyc) begin
                        state_d = GNT0;
                        cnt_d   = '0;
                        last_d  = 1'b1;
                    end else if (cnt_q != QUOTA_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Slave-side mux and ack routing, selected by the registered grant.
    always_comb begin
        s_cyc    = 1'b0;
        s_stb    = 1'b0;
        s_we     = 1'b0;
        s_adr    = '0;
        s_dat_ms = '0;
        s_sel    = '0;
        m0_ack   = 1'b0;
        m1_ack   = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc    = m0_cyc;
                s_stb    = m0_stb;
                s_we     = m0_we;
                s_adr    = m0_adr;
                s_dat_ms = m0_dat_ms;
                s_sel    = m0_sel;
                m0_ack   = s_ack;
            end
            GNT1: begin
                s_cyc    = m1_cyc;
                s_stb    = m1_stb;
                s_we     = m1_we;
                s_adr    = m1_adr;
                s_dat_ms = m1_dat_ms;
                s_sel    = m1_sel;
                m1_ack   = s_ack;
            end
            default: ;
        endcase
    end

    assign gnt    = state_q;
    assign dat_sm = s_dat_sm;

`ifdef WSHB_ARB_STATS_EN
    // Free-running statistics, wrap on overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ack0  <= '0;
            stat_ack1  <= '0;
            stat_wait1 <= '0;
        end else begin
            stat_ack0  <= stat_ack0 + 32'(m0_ack);
            stat_ack1  <= stat_ack1 + 32'(m1_ack);
            stat_wait1 <= stat_wait1 + 32'(m1_cyc & ~state_q[1]);
        end
    end
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Self-checking bench for wshb_arbiter with MAX_BURST=4. Each master's
// transfers are pushed to a per-master queue when presented and popped when
// the master receives its ack.
module tb_wshb_arbiter;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = DAT_W / 8;
    localparam int unsigned MB    = 4;
    localparam int          INF   = 1000000;
    localparam logic [31:0] RD_OFS = 32'h0100_0000;
    localparam logic [31:0] WD_XOR = 32'h5555_0000;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             m0_cyc, m0_stb, m0_we, m0_ack;
    logic [ADR_W-1:0] m0_adr;
    logic [DAT_W-1:0] m0_dat_ms;
    logic [SEL_W-1:0] m0_sel;
    logic             m1_cyc, m1_stb, m1_we, m1_ack;
    logic [ADR_W-1:0] m1_adr;
    logic [DAT_W-1:0] m1_dat_ms;
    logic [SEL_W-1:0] m1_sel;
    logic [DAT_W-1:0] dat_sm;
    logic             s_cyc, s_stb, s_we, s_ack;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat_ms, s_dat_sm;
    logic [SEL_W-1:0] s_sel;
    logic [1:0]       gnt;
`ifdef WSHB_ARB_STATS_EN
    logic [31:0]      stat_ack0, stat_ack1, stat_wait1;
`endif

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic [31:0] rdat;
    } xfer_t;

    xfer_t q0[$];
    xfer_t q1[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    rem0 = 0, rem1 = 0;
    int    acks0 = 0, acks1 = 0;
    logic  ack_en = 1'b0;
    logic  ack_force = 1'b0;

    wshb_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr),
        .m0_dat_ms(m0_dat_ms), .m0_sel(m0_sel), .m0_ack(m0_ack),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr),
        .m1_dat_ms(m1_dat_ms), .m1_sel(m1_sel), .m1_ack(m1_ack),
        .dat_sm(dat_sm),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_ack(s_ack), .s_dat_sm(s_dat_sm),
        .gnt(gnt)
`ifdef WSHB_ARB_STATS_EN
        , .stat_ack0(stat_ack0), .stat_ack1(stat_ack1), .stat_wait1(stat_wait1)
`endif
    );

    always #5 clk = ~clk;

    // Slave model: acks every strobed cycle when enabled, read data derived from address.
    assign s_ack    = ack_force | (ack_en & s_cyc & s_stb);
    assign s_dat_sm = s_adr + RD_OFS;

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic xfer_t exp_of(input logic m, input logic [31:0] adr);
        xfer_t e;
        e.adr  = adr;
        e.we   = m;
        e.sel  = m ? 4'h3 : 4'hF;
        e.wdat = m ? (adr ^ WD_XOR) : 32'h0;
        e.rdat = adr + RD_OFS;
        return e;
    endfunction

    // One clock: sample acks at negedge against the scoreboard, then advance the masters.
    task automatic step();
        xfer_t e;
        logic  a0, a1;
        @(negedge clk);
        a0 = m0_ack;
        a1 = m1_ack;
        n_checks++;
        if (a0 && a1) begin
            n_errors++;
            $display("FAIL both_acks m0_ack=%b m1_ack=%b required at most one", a0, a1);
        end
        if (a0) begin
            acks0++;
            n_checks++;
            if (q0.size() == 0) begin
                n_errors++;
                $display("FAIL sb_m0 ack with no pending transfer, gnt=%b", gnt);
            end else begin
                e = q0.pop_front();
                if ({gnt, s_adr, s_we, s_sel, s_dat_ms, dat_sm} !==
                    {2'b01, e.adr, e.we, e.sel, e.wdat, e.rdat}) begin
                    n_errors++;
                    $display("FAIL sb_m0 got gnt=%b adr=%h we=%b sel=%h wd=%h rd=%h required gnt=01 adr=%h we=%b sel=%h wd=%h rd=%h",
                             gnt, s_adr, s_we, s_sel, s_dat_ms, dat_sm, e.adr, e.we, e.sel, e.wdat, e.rdat);
                end
            end
        end
        if (a1) begin
            acks1++;
            n_checks++;
            if (q1.size() == 0) begin
                n_errors++;
                $display("FAIL sb_m1 ack with no pending transfer, gnt=%b", gnt);
            end else begin
                e = q1.pop_front();
                if ({gnt, s_adr, s_we, s_sel, s_dat_ms, dat_sm} !==
                    {2'b10, e.adr, e.we, e.sel, e.wdat, e.rdat}) begin
                    n_errors++;
                    $display("FAIL sb_m1 got gnt=%b adr=%h we=%b sel=%h wd=%h rd=%h required gnt=10 adr=%h we=%b sel=%h wd=%h rd=%h",
                             gnt, s_adr, s_we, s_sel, s_dat_ms, dat_sm, e.adr, e.we, e.sel, e.wdat, e.rdat);
                end
            end
        end
        @(posedge clk);
        #1;
        if (a0) begin
            rem0--;
            m0_adr = m0_adr + 32'd4;
        end
        if (rem0 > 0) begin
            if (!m0_cyc || a0) q0.push_back(exp_of(1'b0, m0_adr));
            m0_cyc = 1'b1;
            m0_stb = 1'b1;
        end else begin
            m0_cyc = 1'b0;
            m0_stb = 1'b0;
        end
        if (a1) begin
            rem1--;
            m1_adr = m1_adr + 32'd4;
        end
        m1_dat_ms = m1_adr ^ WD_XOR;
        if (rem1 > 0) begin
            if (!m1_cyc || a1) q1.push_back(exp_of(1'b1, m1_adr));
            m1_cyc = 1'b1;
            m1_stb = 1'b1;
        end else begin
            m1_cyc = 1'b0;
            m1_stb = 1'b0;
        end
    endtask

    task automatic wait_gnt(input logic [1:0] g, input int lim, output logic ok);
        ok = (gnt === g);
        for (int i = 0; i < lim && !ok; i++) begin
            step();
            ok = (gnt === g);
        end
    endtask

    // Drop both masters (abandoning any stalled transfer) and let the grant go idle.
    task automatic stop_all();
        rem0 = 0;
        rem1 = 0;
        step();
        q0.delete();
        q1.delete();
        step();
    endtask

    task automatic do_reset();
        rem0 = 0;
        rem1 = 0;
        m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_cyc = 1'b0; m1_stb = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset();
        ack_force = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (gnt !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_gnt got %b required 00", gnt);
        end
        n_checks++;
        if ({s_cyc, s_stb, s_we} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_slave cyc/stb/we got %b required 000", {s_cyc, s_stb, s_we});
        end
        n_checks++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_acks got %b required 00", {m0_ack, m1_ack});
        end
        #2 rst_n = 1'b1;
        step();
        step();
        // s_ack with nobody granted must not produce any master ack
        n_checks++;
        if ({gnt, m0_ack, m1_ack} !== 4'b0000 || acks0 != 0 || acks1 != 0) begin
            n_errors++;
            $display("FAIL idle_ack_ignored got gnt=%b acks=%b/%0d/%0d required 00 00 0 0",
                     gnt, {m0_ack, m1_ack}, acks0, acks1);
        end
        ack_force = 1'b0;
    endtask

    task automatic test_single_master();
        int b0, b1;
        b0 = acks0;
        b1 = acks1;
        rem0 = 6;
        ack_en = 1'b1;
        step();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_errors++;
            $display("FAIL single_latency gnt got %b required 00", gnt);
        end
        step();
        n_checks++;
        if (gnt !== 2'b01 || s_adr !== m0_adr || s_cyc !== 1'b1) begin
            n_errors++;
            $display("FAIL single_grant got gnt=%b adr=%h cyc=%b required 01 %h 1", gnt, s_adr, s_cyc, m0_adr);
        end
        for (int i = 0; i < 20 && rem0 > 0; i++) step();
        n_checks++;
        if (acks0 - b0 != 6 || acks1 - b1 != 0) begin
            n_errors++;
            $display("FAIL single_acks got m0=%0d m1=%0d required 6 0", acks0 - b0, acks1 - b1);
        end
        step();
        n_checks++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
            n_errors++;
            $display("FAIL single_release got gnt=%b cyc=%b required 00 0", gnt, s_cyc);
        end
    endtask

    task automatic test_quota();
        logic ok;
        int   b0, b1;
        rem0 = INF;
        ack_en = 1'b1;
        wait_gnt(2'b01, 5, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL quota_m0_grant timeout gnt=%b required 01", gnt);
        end
        repeat (8) step();
        rem1 = INF;
        step();
        step();
        n_checks++;
        if (gnt !== 2'b10) begin
            n_errors++;
            $display("FAIL quota_switch got gnt=%b required 10", gnt);
        end
        b1 = acks1;
        wait_gnt(2'b01, 20, ok);
        n_checks++;
        if (!ok || acks1 - b1 != MB) begin
            n_errors++;
            $display("FAIL quota_m1_burst got gnt=%b acks=%0d required 01 %0d", gnt, acks1 - b1, MB);
        end
        b0 = acks0;
        wait_gnt(2'b10, 20, ok);
        n_checks++;
        if (!ok || acks0 - b0 != MB) begin
            n_errors++;
            $display("FAIL quota_m0_burst got gnt=%b acks=%0d required 10 %0d", gnt, acks0 - b0, MB);
        end
        stop_all();
    endtask

    task automatic test_tie();
        do_reset();
        rem0 = INF;
        rem1 = INF;
        step();
        step();
        n_checks++;
        if (gnt !== 2'b01) begin
            n_errors++;
            $display("FAIL tie_first got gnt=%b required 01", gnt);
        end
        stop_all();
        n_checks++;
        if (gnt !== 2'b00) begin
            n_errors++;
            $display("FAIL tie_idle got gnt=%b required 00", gnt);
        end
        rem0 = INF;
        rem1 = INF;
        step();
        step();
        n_checks++;
        if (gnt !== 2'b10) begin
            n_errors++;
            $display("FAIL tie_second got gnt=%b required 10", gnt);
        end
        stop_all();
    endtask

    task automatic test_ack_stall();
        logic ok;
        int   b1, held;
        rem1 = INF;
        ack_en = 1'b1;
        wait_gnt(2'b10, 5, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL stall_m1_grant timeout gnt=%b required 10", gnt);
        end
        repeat (5) step();
        ack_en = 1'b0;
        rem0 = INF;
        b1 = acks1;
        held = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            if (gnt === 2'b10) held++;
        end
        n_checks++;
        if (held != 5 || acks1 != b1) begin
            n_errors++;
            $display("FAIL stall_hold got held=%0d acks=%0d required 5 0", held, acks1 - b1);
        end
        ack_en = 1'b1;
        step();
        n_checks++;
        if (gnt !== 2'b01 || acks1 - b1 != 1 || q1.size() != 1) begin
            n_errors++;
            $display("FAIL stall_switch got gnt=%b acks=%0d pend=%0d required 01 1 1",
                     gnt, acks1 - b1, q1.size());
        end
        stop_all();
    endtask

    task automatic test_release();
        int b1;
        rem1 = 2;
        ack_en = 1'b1;
        step();
        step();
        n_checks++;
        if (gnt !== 2'b10) begin
            n_errors++;
            $display("FAIL release_m1_grant got gnt=%b required 10", gnt);
        end
        rem0 = INF;
        b1 = acks1;
        step();
        step();
        n_checks++;
        if (gnt !== 2'b10 || acks1 - b1 != 2) begin
            n_errors++;
            $display("FAIL release_m1_acks got gnt=%b acks=%0d required 10 2", gnt, acks1 - b1);
        end
        step();
        n_checks++;
        if (gnt !== 2'b01) begin
            n_errors++;
            $display("FAIL release_handover got gnt=%b required 01", gnt);
        end
        rem0 = 0;
        step();
        step();
        n_checks++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0) begin
            n_errors++;
            $display("FAIL release_idle got gnt=%b cyc=%b required 00 0", gnt, s_cyc);
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic test_reset_mid();
        logic ok;
        rem1 = INF;
        ack_en = 1'b1;
        wait_gnt(2'b10, 5, ok);
        ack_en = 1'b0;
        step();
        n_checks++;
        if (!ok || {gnt, s_cyc, s_stb} !== 4'b1011) begin
            n_errors++;
            $display("FAIL rstmid_pre got gnt=%b cyc=%b stb=%b required 10 1 1", gnt, s_cyc, s_stb);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, s_cyc, s_stb} !== 4'b0000) begin
            n_errors++;
            $display("FAIL rstmid_async got gnt=%b cyc=%b stb=%b required 00 0 0", gnt, s_cyc, s_stb);
        end
`ifdef WSHB_ARB_STATS_EN
        n_checks++;
        if ({stat_ack0, stat_ack1, stat_wait1} !== 96'h0) begin
            n_errors++;
            $display("FAIL rstmid_stats got %0d %0d %0d required 0 0 0", stat_ack0, stat_ack1, stat_wait1);
        end
`endif
        rem1 = 0;
        m1_cyc = 1'b0;
        m1_stb = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        q0.delete();
        q1.delete();
    endtask

    initial begin
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_sel = 4'hF;
        m0_adr = 32'h0000_1000; m0_dat_ms = 32'h0;
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b1; m1_sel = 4'h3;
        m1_adr = 32'h8000_0000; m1_dat_ms = 32'h8000_0000 ^ WD_XOR;
        test_reset();
        test_single_master();
        test_quota();
        test_tie();
        test_ack_stall();
        test_release();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
